// File: rtl/mul_pkg.sv
// Shared constants and helpers for the multiply path: product width, default
// accumulator/counter widths and the saturation rails for a given width.
package mul_pkg;

  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 32;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Rails are returned at 64 bits; callers narrow them to their own width.
  function automatic logic signed [63:0] acc_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/mul_accumulator_sat_add.sv
// Combinational saturating add of a sign-extended 16-bit product onto an
// ACC_W-bit signed accumulator; ovf flags that the result was clamped.
module sat_add
  import mul_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  a,
  input  logic signed [PROD_W-1:0] b,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  localparam logic signed [ACC_W:0]   MAX_EXT = (ACC_W + 1)'(acc_max(ACC_W));
  localparam logic signed [ACC_W:0]   MIN_EXT = (ACC_W + 1)'(acc_min(ACC_W));
  localparam logic signed [ACC_W-1:0] MAX_V   = ACC_W'(acc_max(ACC_W));
  localparam logic signed [ACC_W-1:0] MIN_V   = ACC_W'(acc_min(ACC_W));

  logic signed [ACC_W:0] a_ext;
  logic signed [ACC_W:0] b_ext;
  logic signed [ACC_W:0] s;

  // One guard bit is enough: a 16-bit addend can overshoot a rail by < 2^15.
  assign a_ext = {a[ACC_W-1], a};
  assign b_ext = {{(ACC_W + 1 - PROD_W){b[PROD_W-1]}}, b};
  assign s     = a_ext + b_ext;

  always_comb begin
    sum = s[ACC_W-1:0];
    ovf = 1'b0;
    if (s > MAX_EXT) begin
      sum = MAX_V;
      ovf = 1'b1;
    end else if (s < MIN_EXT) begin
      sum = MIN_V;
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/mul_accumulator.sv
// Saturating multiply-accumulate back end: sums a stream of signed products per
// group and presents {sum, count, sat} in a single registered output slot.
module mul_accumulator
  import mul_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_sat,
  output slot_state_t              slot_state
);

  // Handshake: a beat moves on a channel in any cycle where valid & ready are
  // both high at the rising edge. in_ready depends only on the slot state and
  // out_ready, never on in_valid; out_valid/out_* are registered and held
  // stable while out_valid is high and out_ready is low.

  slot_state_t slot_q, slot_d;

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    sat;

  logic signed [ACC_W-1:0] sum;
  logic                    ovf;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    accept;
  logic                    last_accept;
  logic                    out_xfer;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (in_data),
    .sum (sum),
    .ovf (ovf)
  );

  assign out_valid   = (slot_q == SLOT_FULL);
  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && in_last;
  assign out_xfer    = out_valid && out_ready;
  assign cnt_inc     = (&cnt) ? cnt : cnt + 1'b1;
  assign slot_state  = slot_q;

  always_ff @(posedge clk) begin
    if (rst) slot_q <= SLOT_EMPTY;
    else     slot_q <= slot_d;
  end

  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      SLOT_EMPTY: if (last_accept) slot_d = SLOT_FULL;
      SLOT_FULL:  if (out_xfer && !last_accept) slot_d = SLOT_EMPTY;
      default:    slot_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        // Close the group into the slot and start the next one from zero.
        out_data  <= sum;
        out_count <= cnt_inc;
        out_sat   <= sat | ovf;
        acc       <= '0;
        cnt       <= '0;
        sat       <= 1'b0;
      end else begin
        acc <= sum;
        cnt <= cnt_inc;
        sat <= sat | ovf;
      end
    end
  end

endmodule

// File: tb/tb_mul_accumulator.sv
// Bench for mul_accumulator: a 32-bit and a 17-bit instance share one stimulus
// stream; directed vector table, hand sequences, then a randomized model run.
module tb_mul_accumulator;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;

  logic in_ready32, in_ready17;
  logic out_valid32, out_valid17;
  logic signed [31:0] out_data32;
  logic signed [16:0] out_data17;
  logic [7:0] out_count32, out_count17;
  logic out_sat32, out_sat17;
  slot_state_t st32, st17;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mul_accumulator #(.ACC_W(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid32),
    .out_ready(out_ready), .out_data(out_data32), .out_count(out_count32),
    .out_sat(out_sat32), .slot_state(st32)
  );

  mul_accumulator #(.ACC_W(17), .CNT_W(8)) dut17 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready17),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid17),
    .out_ready(out_ready), .out_data(out_data17), .out_count(out_count17),
    .out_sat(out_sat17), .slot_state(st17)
  );

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst, v, last, ordy;
    logic signed [15:0] d;
    logic exp_rdy, exp_valid, chk_dat;
    longint exp_d32, exp_d17;
    int exp_cnt;
    logic exp_s32, exp_s17;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic v, input int d, input logic l,
                     input logic o, input logic er, input logic ev,
                     input logic ck, input longint d32, input longint d17,
                     input int c, input logic s32, input logic s17);
    vec_t t;
    t.rst = r; t.v = v; t.d = 16'(d); t.last = l; t.ordy = o;
    t.exp_rdy = er; t.exp_valid = ev; t.chk_dat = ck;
    t.exp_d32 = d32; t.exp_d17 = d17; t.exp_cnt = c;
    t.exp_s32 = s32; t.exp_s17 = s17;
    vq.push_back(t);
  endtask

  task automatic drive(input logic r, input logic v, input int d,
                       input logic l, input logic o);
    @(negedge clk);
    rst = r; in_valid = v; in_data = 16'(d); in_last = l; out_ready = o;
  endtask

  task automatic check_out(input string tag, input longint d32,
                           input longint d17, input int c, input logic s32,
                           input logic s17);
    chk({tag, ".valid32"}, out_valid32, 1'b1);
    chk({tag, ".valid17"}, out_valid17, 1'b1);
    chk({tag, ".data32"}, out_data32, d32);
    chk({tag, ".data17"}, out_data17, d17);
    chk({tag, ".count32"}, out_count32, c);
    chk({tag, ".count17"}, out_count17, c);
    chk({tag, ".sat32"}, out_sat32, s32);
    chk({tag, ".sat17"}, out_sat17, s17);
  endtask

  // Reference state for the random phase, index 0 = 32-bit, 1 = 17-bit.
  longint m_acc[2];
  logic   m_sat[2];
  longint e_d[2];
  logic   e_s[2];
  int     m_cnt, e_c;
  logic   m_full;
  int     wv[2] = '{32, 17};

  initial begin
    string tag;
    // Test-plan sequences; exp_* describe state after the edge.
    add(0,1,-500,1,1, 1,1,1, -500,-500,1,0,0);
    add(0,1,100,0,1, 1,0,0, 0,0,0,0,0);
    add(0,1,-75,0,1, 1,0,0, 0,0,0,0,0);
    add(0,1,32766,0,1, 1,0,0, 0,0,0,0,0);
    add(0,1,0,1,1, 1,1,1, 32791,32791,4,0,0);
    add(0,1,32767,0,1, 1,0,0, 0,0,0,0,0);
    add(0,1,32767,0,1, 1,0,0, 0,0,0,0,0);
    add(0,1,32767,1,1, 1,1,1, 98301,65535,3,0,1);
    add(0,1,5,1,1, 1,1,1, 5,5,1,0,0);
    add(0,0,0,0,1, 1,0,0, 0,0,0,0,0);
    add(0,1,7,1,0, 1,1,1, 7,7,1,0,0);
    for (int i = 0; i < 5; i++) add(0,1,9,1,0, 0,1,1, 7,7,1,0,0);
    add(0,1,9,1,1, 1,1,1, 9,9,1,0,0);
    add(0,1,1,1,1, 1,1,1, 1,1,1,0,0);
    add(0,1,2,1,1, 1,1,1, 2,2,1,0,0);
    add(0,1,3,1,1, 1,1,1, 3,3,1,0,0);
    add(0,0,0,0,1, 1,0,0, 0,0,0,0,0);
    add(0,1,10,0,1, 1,0,0, 0,0,0,0,0);
    add(0,1,20,0,1, 1,0,0, 0,0,0,0,0);
    add(1,0,0,0,1, 1,0,1, 0,0,0,0,0);
    add(0,1,4,1,1, 1,1,1, 4,4,1,0,0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.valid32", out_valid32, 1'b0);
    chk("reset.valid17", out_valid17, 1'b0);
    chk("reset.data32", out_data32, 0);
    chk("reset.count32", out_count32, 0);
    chk("reset.sat32", out_sat32, 1'b0);
    chk("reset.ready32", in_ready32, 1'b1);
    chk("reset.ready17", in_ready17, 1'b1);
    chk("reset.slot32", st32, SLOT_EMPTY);
    chk("reset.slot17", st17, SLOT_EMPTY);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].v, int'(vq[i].d), vq[i].last, vq[i].ordy);
      #1;
      tag = $sformatf("v%0d", i);
      chk({tag, ".rdy32"}, in_ready32, vq[i].exp_rdy);
      chk({tag, ".rdy17"}, in_ready17, vq[i].exp_rdy);
      @(posedge clk);
      #1;
      chk({tag, ".valid32"}, out_valid32, vq[i].exp_valid);
      chk({tag, ".valid17"}, out_valid17, vq[i].exp_valid);
      if (vq[i].chk_dat) begin
        chk({tag, ".data32"}, out_data32, vq[i].exp_d32);
        chk({tag, ".data17"}, out_data17, vq[i].exp_d17);
        chk({tag, ".count32"}, out_count32, vq[i].exp_cnt);
        chk({tag, ".count17"}, out_count17, vq[i].exp_cnt);
        chk({tag, ".sat32"}, out_sat32, vq[i].exp_s32);
        chk({tag, ".sat17"}, out_sat17, vq[i].exp_s17);
      end
    end

    // Term counter sticks at 255 over a 300-product group.
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 1, (i == 299), 1);
      @(posedge clk);
    end
    #1;
    check_out("cntwrap", 300, 300, 255, 0, 0);

    // Clamped sum moves back off the rail on an opposite-sign product.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, (i == 3) ? -1000 : 32767, (i == 3), 1);
      @(posedge clk);
    end
    #1;
    check_out("offrail", 97301, 64535, 4, 0, 1);

    // Randomized run against the arithmetic model.
    drive(1, 0, 0, 0, 1);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_sat[k] = 0; e_d[k] = 0; e_s[k] = 0;
    end
    m_cnt = 0; e_c = 0; m_full = 0;
    for (int n = 0; n < 2000; n++) begin
      logic v, l, o, er, ov;
      int d, c;
      longint s, hi, lo;
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 2))
        0: d = $urandom_range(0, 65535) - 32768;
        1: d = 32767 - $urandom_range(0, 2000);
        default: d = -32768 + $urandom_range(0, 2000);
      endcase
      drive(0, v, d, l, o);
      #1;
      er = !m_full || o;
      chk($sformatf("r%0d.rdy32", n), in_ready32, er);
      chk($sformatf("r%0d.rdy17", n), in_ready17, er);
      @(posedge clk);
      if (o) m_full = 0;
      if (v && er) begin
        c = (m_cnt == 255) ? 255 : m_cnt + 1;
        for (int k = 0; k < 2; k++) begin
          hi = (64'sd1 <<< (wv[k] - 1)) - 1;
          lo = -(64'sd1 <<< (wv[k] - 1));
          s = m_acc[k] + longint'(d);
          ov = 0;
          if (s > hi) begin s = hi; ov = 1; end
          else if (s < lo) begin s = lo; ov = 1; end
          if (l) begin
            e_d[k] = s; e_s[k] = m_sat[k] | ov; m_acc[k] = 0; m_sat[k] = 0;
          end else begin
            m_acc[k] = s; m_sat[k] = m_sat[k] | ov;
          end
        end
        if (l) begin e_c = c; m_cnt = 0; m_full = 1; end
        else m_cnt = c;
      end
      #1;
      chk($sformatf("r%0d.valid32", n), out_valid32, m_full);
      chk($sformatf("r%0d.valid17", n), out_valid17, m_full);
      if (m_full) check_out($sformatf("r%0d", n), e_d[0], e_d[1], e_c, e_s[0], e_s[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
